// File: rtl/tone_sequencer.sv
// tone_sequencer: square-wave note player with a valid/ready note interface.
// Each accepted note plays for note_dur milliseconds, then stays silent for
// GAP_MS milliseconds. note_done pulses on the first idle cycle afterwards.
module tone_sequencer #(
    parameter int CLK_FREQ = 50000000,
    parameter int DUR_W    = 12,
    parameter int GAP_MS   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note_code,
    input  logic [1:0]       note_octave,
    input  logic [DUR_W-1:0] note_dur,
    input  logic             abort,
    output logic             out,
    output logic             busy,
    output logic             note_done
);

    localparam int MS_TICKS  = CLK_FREQ / 1000;
    localparam int GAP_TICKS = GAP_MS * MS_TICKS;
    // The lowest note (C3) has the longest half-period, so it sets the counter width.
    localparam int HP_W      = $clog2(CLK_FREQ / (2 * 131) + 1);
    localparam int MS_W      = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam int GAP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_TICKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    // Half-period in clock cycles for each note code; code 0 is a rest.
    function automatic int hp_of(input int code);
        int freq;
        case (code)
            1:       freq = 131;
            2:       freq = 147;
            3:       freq = 165;
            4:       freq = 175;
            5:       freq = 196;
            6:       freq = 220;
            7:       freq = 247;
            8:       freq = 262;
            9:       freq = 294;
            10:      freq = 330;
            11:      freq = 349;
            12:      freq = 392;
            13:      freq = 440;
            14:      freq = 494;
            15:      freq = 523;
            default: freq = 0;
        endcase
        return (freq == 0) ? 0 : CLK_FREQ / (2 * freq);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_reg;
    logic               out_reg;
    logic               busy_reg;
    logic               ready_reg;
    logic               done_reg;
    logic               rest_reg;
    logic [HP_W-1:0]    half_reg;
    logic [HP_W-1:0]    phase_reg;
    logic [DUR_W-1:0]   dur_reg;
    logic [MS_W-1:0]    ms_reg;
    logic [GAP_W-1:0]   gap_reg;

    logic [HP_W-1:0]    hp_table [16];
    logic [HP_W-1:0]    shifted_half;
    logic [HP_W-1:0]    eff_half;

    // Constant half-period lookup table, built at elaboration.
    for (genvar gi = 0; gi < 16; gi++) begin : g_hp
        assign hp_table[gi] = HP_W'(hp_of(gi));
    end

    // Octave shift halves the period per step; never let it drop to zero.
    assign shifted_half = hp_table[note_code] >> note_octave;
    assign eff_half     = (shifted_half == '0) ? HP_W'(1) : shifted_half;

    assign note_ready = ready_reg;
    assign out        = out_reg;
    assign busy       = busy_reg;
    assign note_done  = done_reg;

    // Sequencer FSM: accept, play with ms timing, optional gap, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
            rest_reg  <= 1'b0;
            half_reg  <= '0;
            phase_reg <= '0;
            dur_reg   <= '0;
            ms_reg    <= '0;
            gap_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (note_valid && ready_reg) begin
                        if (note_dur == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= PLAY;
                            busy_reg  <= 1'b1;
                            ready_reg <= 1'b0;
                            half_reg  <= eff_half;
                            rest_reg  <= (note_code == 4'd0);
                            dur_reg   <= note_dur;
                            phase_reg <= '0;
                            ms_reg    <= '0;
                            out_reg   <= 1'b0;
                        end
                    end
                end
                PLAY: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        out_reg   <= 1'b0;
                        phase_reg <= '0;
                        ms_reg    <= '0;
                        dur_reg   <= '0;
                    end else begin
                        if (phase_reg == half_reg - HP_W'(1)) begin
                            phase_reg <= '0;
                            if (!rest_reg) begin
                                out_reg <= ~out_reg;
                            end
                        end else begin
                            phase_reg <= phase_reg + HP_W'(1);
                        end
                        if (ms_reg == MS_LAST) begin
                            ms_reg  <= '0;
                            dur_reg <= dur_reg - DUR_W'(1);
                            if (dur_reg == DUR_W'(1)) begin
                                // Last ms elapsed: silence the pin regardless of phase.
                                out_reg   <= 1'b0;
                                phase_reg <= '0;
                                if (GAP_MS == 0) begin
                                    state_reg <= IDLE;
                                    busy_reg  <= 1'b0;
                                    ready_reg <= 1'b1;
                                    done_reg  <= 1'b1;
                                end else begin
                                    state_reg <= GAP;
                                    gap_reg   <= '0;
                                end
                            end
                        end else begin
                            ms_reg <= ms_reg + MS_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        gap_reg   <= '0;
                    end else if (gap_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        gap_reg   <= '0;
                    end else begin
                        gap_reg <= gap_reg + GAP_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    out_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the fixed-table square-wave tone generator.
- Accepts timed note requests over a valid/ready handshake.
- Computes half-period counts from the CLK_FREQ parameter, supports octave shifting, and times each note and an inter-note gap in milliseconds.
- Sits between a game/melody controller and the speaker pin. Signals completion so a melody can be streamed note by note.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz; all counts derive from it.
- DUR_W, 12, width of note duration field (ms units).
- GAP_MS, 10, silent ms inserted after every played note; 0 = no gap.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- note_valid  input  1  note request present
- note_ready  output  1  block can accept a note (high only in IDLE)
- note_code  input  4  0=rest; 1..15 = C3,D3,E3,F3,G3,A3,B3,C4,D4,E4,F4,G4,A4,B4,C5 (131,147,165,175,196,220,247,262,294,330,349,392,440,494,523 Hz)
- note_octave  input  2  raise pitch by 2^note_octave
- note_dur  input  DUR_W  note length in ms
- abort  input  1  cancel current note/gap immediately
- out  output  1  square-wave speaker output
- busy  output  1  high in PLAY or GAP
- note_done  output  1  one-cycle pulse when a note (incl. its gap) finishes

Behaviour:
- Reset: state IDLE; out=0, busy=0, note_done=0, note_ready=1; all counters 0. Reset overrides abort and handshake; a reset mid-note produces no note_done.
- Derived constants:
  - MS_TICKS = CLK_FREQ/1000 (integer).
  - Base half-period HP(code) = floor(CLK_FREQ/(2*f)) from an elaboration-time function. The counter is wide enough for HP(C3).
- Effective half-period = HP >> note_octave, clamped to minimum 1. This value is latched at accept.
- States:
  - IDLE: note_ready=1. Accept when note_valid && note_ready at edge t0. Latch code, effective half-period and duration.
    - note_dur=0: stay in IDLE; note_done=1 in cycle t0+1.
    - Otherwise go to PLAY.
  - PLAY, cycles t0+1 .. t0+note_dur*MS_TICKS:
    - Phase counter starts at 0 with out=0. out toggles when phase == half-1, and phase returns to 0.
    - code 0 (rest): out held 0, timing identical.
    - A ms prescaler counts MS_TICKS cycles and decrements the remaining ms; when it reaches zero, go to GAP, or to IDLE if GAP_MS=0.
    - out is forced 0 on exit.
  - GAP: GAP_MS*MS_TICKS cycles with out=0, then IDLE.
- note_done is high in the first IDLE cycle after PLAY/GAP. With default timing that is cycle t0+(note_dur+GAP_MS)*MS_TICKS+1.
- busy=1 exactly while state is PLAY or GAP. note_ready=0 then; requests are held off, not dropped.
- abort in PLAY or GAP: next cycle is IDLE with out=0, no note_done, counters cleared. abort in IDLE has no effect. If abort and note_valid are both high in IDLE, the note is accepted.
- Back-to-back notes: at least one IDLE cycle between consecutive notes. A request held valid during that cycle is accepted there.
- Inputs are sampled only at accept; changes during PLAY are ignored.

Test Plan:
- All tests use CLK_FREQ=1000000 (MS_TICKS=1000), GAP_MS=1.
- Reset then A4 (code 13), oct 0, dur 2 accepted at t0 -> busy cycles t0+1..t0+3000; out rises at t0+1136, forced 0 at t0+2001; note_done single pulse at t0+3001.
- A4 oct 1, dur 5 -> out toggles every 568 cycles during PLAY; period 1136 cycles.
- C5 (code 15) oct 3 -> half-period 956>>3=119. C3 (code 1) oct 0 -> half-period 3816; first toggle at t0+3816.
- Rest (code 0) dur 3 -> out constantly 0; note_done at t0+4001.
- dur 0 -> no busy; note_done at t0+1. abort at t0+500 of a dur-2 note -> IDLE at t0+501, out=0, no note_done.
- rst asserted mid-PLAY -> all outputs at reset values next cycle. note_valid held high continuously -> notes accepted every (dur+1)*1000+1 cycles with one IDLE cycle between them.
